// File: rtl/friscv_uart_arbiter.sv
// friscv_uart_arbiter
// Shares a single UART register port between two requesters (m0, m1).
// After reset it first programs the UART itself: the clock divider goes to
// register 0x4, then the control byte goes to register 0x0. Only after that
// does it serve requesters. Requesters are served one at a time, in
// round-robin order.
//
// Ports
//   aclk, srst            clock, synchronous active-high reset
//   mX_en/wr/addr/wdata/strb
//                         requester X command (X = 0, 1)
//   mX_rdata, mX_ready    requester X read data and one-cycle completion pulse
//   uart_en/wr/addr/wdata/strb
//                         command to the UART (registered)
//   uart_rdata, uart_ready
//                         UART response
//   init_done             boot configuration finished
//   busy                  the arbiter is not in IDLE
module friscv_uart_arbiter #(
   parameter int         ADDRW        = 16,
   parameter int         XLEN         = 32,
   parameter int         INIT_DIVIDER = 4,
   parameter logic [7:0] INIT_CTRL    = 8'h01
)(
   input  logic              aclk,
   input  logic              srst,
   input  logic              m0_en,
   input  logic              m0_wr,
   input  logic [ADDRW-1:0]  m0_addr,
   input  logic [XLEN-1:0]   m0_wdata,
   input  logic [XLEN/8-1:0] m0_strb,
   output logic [XLEN-1:0]   m0_rdata,
   output logic              m0_ready,
   input  logic              m1_en,
   input  logic              m1_wr,
   input  logic [ADDRW-1:0]  m1_addr,
   input  logic [XLEN-1:0]   m1_wdata,
   input  logic [XLEN/8-1:0] m1_strb,
   output logic [XLEN-1:0]   m1_rdata,
   output logic              m1_ready,
   output logic              uart_en,
   output logic              uart_wr,
   output logic [ADDRW-1:0]  uart_addr,
   output logic [XLEN-1:0]   uart_wdata,
   output logic [XLEN/8-1:0] uart_strb,
   input  logic [XLEN-1:0]   uart_rdata,
   input  logic              uart_ready,
   output logic              init_done,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_INIT_DIV,
      ST_INIT_CTRL,
      ST_IDLE,
      ST_XFER,
      ST_DONE
   } state_t;

   state_t state_reg, state_next;

   // Requester ports gathered into arrays, so that the grant index selects
   // one of them directly.
   logic [1:0]        req_en;
   logic [1:0]        req_wr;
   logic [ADDRW-1:0]  req_addr  [2];
   logic [XLEN-1:0]   req_wdata [2];
   logic [XLEN/8-1:0] req_strb  [2];

   assign req_en       = {m1_en, m0_en};
   assign req_wr       = {m1_wr, m0_wr};
   assign req_addr[0]  = m0_addr;
   assign req_addr[1]  = m1_addr;
   assign req_wdata[0] = m0_wdata;
   assign req_wdata[1] = m1_wdata;
   assign req_strb[0]  = m0_strb;
   assign req_strb[1]  = m1_strb;

   logic              uart_en_reg, uart_en_next;
   logic              uart_wr_reg, uart_wr_next;
   logic [ADDRW-1:0]  uart_addr_reg, uart_addr_next;
   logic [XLEN-1:0]   uart_wdata_reg, uart_wdata_next;
   logic [XLEN/8-1:0] uart_strb_reg, uart_strb_next;
   logic [XLEN-1:0]   rdata_reg [2];
   logic [XLEN-1:0]   rdata_next [2];
   logic [1:0]        ready_reg, ready_next;
   logic              init_done_reg, init_done_next;
   logic              busy_reg, busy_next;
   logic              grant_reg, grant_next;   // requester currently being served
   logic              ptr_reg, ptr_next;       // requester that wins a tie
   logic              pick;

   // When both requesters ask, the pointer decides. A lone requester always wins.
   assign pick = (req_en == 2'b11) ? ptr_reg : req_en[1];

   // State register
   always_ff @(posedge aclk) begin
      if (srst) begin
         state_reg <= ST_INIT_DIV;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         // A completion counts only while a write is actually on the bus.
         // uart_en is low for the first cycle after reset.
         ST_INIT_DIV:  if (uart_en_reg && uart_ready) state_next = ST_INIT_CTRL;
         ST_INIT_CTRL: if (uart_en_reg && uart_ready) state_next = ST_IDLE;
         ST_IDLE:      if (|req_en)                   state_next = ST_XFER;
         ST_XFER:      if (uart_ready)                state_next = ST_DONE;
         ST_DONE:                                     state_next = ST_IDLE;
         default:                                     state_next = ST_INIT_DIV;
      endcase
   end

   // Output logic: computes the values that the output registers load next
   always_comb begin
      uart_en_next    = uart_en_reg;
      uart_wr_next    = uart_wr_reg;
      uart_addr_next  = uart_addr_reg;
      uart_wdata_next = uart_wdata_reg;
      uart_strb_next  = uart_strb_reg;
      rdata_next      = rdata_reg;
      ready_next      = 2'b00;
      init_done_next  = init_done_reg;
      grant_next      = grant_reg;
      ptr_next        = ptr_reg;
      case (state_reg)
         ST_INIT_DIV: begin
            // uart_en stays high when moving to the control write. The UART
            // ignores the cycle in which it returns ready.
            uart_en_next   = 1'b1;
            uart_wr_next   = 1'b1;
            uart_strb_next = {(XLEN/8){1'b1}};
            if (state_next == ST_INIT_CTRL) begin
               uart_addr_next  = '0;
               uart_wdata_next = XLEN'(INIT_CTRL);
            end else begin
               uart_addr_next  = ADDRW'(4);
               uart_wdata_next = XLEN'(INIT_DIVIDER);
            end
         end
         ST_INIT_CTRL: begin
            if (state_next == ST_IDLE) begin
               uart_en_next   = 1'b0;
               init_done_next = 1'b1;
            end else begin
               uart_en_next    = 1'b1;
               uart_wr_next    = 1'b1;
               uart_addr_next  = '0;
               uart_wdata_next = XLEN'(INIT_CTRL);
               uart_strb_next  = {(XLEN/8){1'b1}};
            end
         end
         ST_IDLE: begin
            if (|req_en) begin
               grant_next      = pick;
               uart_en_next    = 1'b1;
               uart_wr_next    = req_wr[pick];
               uart_addr_next  = req_addr[pick];
               uart_wdata_next = req_wdata[pick];
               uart_strb_next  = req_strb[pick];
            end
         end
         ST_XFER: begin
            if (uart_ready) begin
               uart_en_next          = 1'b0;
               rdata_next[grant_reg] = uart_rdata;
               ready_next[grant_reg] = 1'b1;
               ptr_next              = ~grant_reg;
            end
         end
         default: ;
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   // Output registers
   always_ff @(posedge aclk) begin
      if (srst) begin
         uart_en_reg    <= 1'b0;
         uart_wr_reg    <= 1'b0;
         uart_addr_reg  <= '0;
         uart_wdata_reg <= '0;
         uart_strb_reg  <= '0;
         rdata_reg[0]   <= '0;
         rdata_reg[1]   <= '0;
         ready_reg      <= 2'b00;
         init_done_reg  <= 1'b0;
         busy_reg       <= 1'b1;
         grant_reg      <= 1'b0;
         ptr_reg        <= 1'b0;
      end else begin
         uart_en_reg    <= uart_en_next;
         uart_wr_reg    <= uart_wr_next;
         uart_addr_reg  <= uart_addr_next;
         uart_wdata_reg <= uart_wdata_next;
         uart_strb_reg  <= uart_strb_next;
         rdata_reg[0]   <= rdata_next[0];
         rdata_reg[1]   <= rdata_next[1];
         ready_reg      <= ready_next;
         init_done_reg  <= init_done_next;
         busy_reg       <= busy_next;
         grant_reg      <= grant_next;
         ptr_reg        <= ptr_next;
      end
   end

   assign uart_en    = uart_en_reg;
   assign uart_wr    = uart_wr_reg;
   assign uart_addr  = uart_addr_reg;
   assign uart_wdata = uart_wdata_reg;
   assign uart_strb  = uart_strb_reg;
   assign m0_rdata   = rdata_reg[0];
   assign m1_rdata   = rdata_reg[1];
   assign m0_ready   = ready_reg[0];
   assign m1_ready   = ready_reg[1];
   assign init_done  = init_done_reg;
   assign busy       = busy_reg;

endmodule

// File: doc/friscv_uart_arbiter.md
FRISCV_UART_ARBITER -- requirements
Module: friscv_uart_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRW, default 16, APB address width.
REQ-002 The block SHALL have parameter XLEN, default 32, data width.
REQ-003 The block SHALL have parameter INIT_DIVIDER, default 4, clock divider written to UART register 0x4 at boot.
REQ-004 The block SHALL have parameter INIT_CTRL, default 8'h01, control byte written to UART register 0x0 at boot.
REQ-005 The block SHALL use a single clock and a synchronous, active-high reset, with these ports:
- aclk  in  1  clock.
- srst  in  1  synchronous active-high reset.
REQ-006 For each requester mX (X = 0, 1), the block SHALL have these ports:
- mX_en  in  1  request.
- mX_wr  in  1  write (1) or read (0).
- mX_addr  in  ADDRW  address.
- mX_wdata  in  XLEN  write data.
- mX_strb  in  XLEN/8  write byte strobes.
- mX_rdata  out  XLEN  read data.
- mX_ready  out  1  completion pulse.
REQ-007 The block SHALL have these UART-side ports:
- uart_en  out  1  request.
- uart_wr  out  1  write (1) or read (0).
- uart_addr  out  ADDRW  address.
- uart_wdata  out  XLEN  write data.
- uart_strb  out  XLEN/8  write byte strobes.
- uart_rdata  in  XLEN  read data.
- uart_ready  in  1  completion.
REQ-008 The block SHALL have these status ports:
- init_done  out  1  boot configuration complete.
- busy  out  1  state is not IDLE.

Function
REQ-009 The FSM SHALL have the states INIT_DIV, INIT_CTRL, IDLE, XFER and DONE; all outputs SHALL be registered.
REQ-010 In INIT_DIV, the block SHALL drive uart_en=1, uart_wr=1, uart_addr=0x4, uart_wdata=INIT_DIVIDER (zero-extended) and uart_strb=all ones.
- On uart_ready=1, the next state SHALL be INIT_CTRL.
REQ-011 In INIT_CTRL, the block SHALL drive uart_en=1, uart_wr=1, uart_addr=0x0, uart_wdata=INIT_CTRL (zero-extended) and uart_strb=all ones.
- On uart_ready=1, the block SHALL set uart_en<=0 and init_done<=1, and go to IDLE.
REQ-012 Between the two init writes, uart_en SHALL remain 1.
- The cycle in which uart_ready=1 is ignored by the UART, so no idle gap is required.
REQ-013 While init_done=0, requester requests SHALL be held pending: no mX_ready is issued and no request is lost.
REQ-014 In IDLE, if any mX_en=1, the block SHALL grant one requester, copy its wr/addr/wdata/strb to the uart_* outputs, set uart_en<=1, and go to XFER.
REQ-015 Arbitration SHALL be round-robin.
- A pointer SHALL give priority to m0 after reset and to the non-last-served requester afterwards.
- A lone requester SHALL always win.
REQ-016 In XFER, uart_* outputs SHALL be held stable until uart_ready=1.
- On that cycle: uart_en<=0, granted mX_rdata<=uart_rdata, granted mX_ready<=1, pointer updated, next state DONE.
REQ-017 In DONE, mX_ready SHALL return to 0 (exactly a one-cycle pulse), and the next state SHALL be IDLE.
- Requests present in DONE SHALL NOT be sampled.
REQ-018 The non-granted requester's mX_rdata and mX_ready SHALL be unchanged during another requester's transfer.
REQ-019 mX_rdata SHALL hold its last value until that requester's next completion.
REQ-020 Latency: with a request sampled in IDLE at cycle t, uart_en=1 at t+1; if uart_ready=1 at cycle r, then mX_ready=1 at r+1.
- Minimum round trip SHALL be 4 cycles from request to next IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 No timeout SHALL exist; a UART that never asserts uart_ready stalls the block until srst.

Reset
REQ-023 On srst=1, the block SHALL go to state INIT_DIV and set uart_en=0, uart_wr=0, uart_addr=0, uart_wdata=0, uart_strb=0.
- Also: both mX_ready=0, both mX_rdata=0, init_done=0, busy=1, pointer=m0.
REQ-024 srst asserted mid-transfer SHALL abandon the transfer without an mX_ready pulse.
- After srst deasserts, the init sequence SHALL be re-run in full.
REQ-025 After srst deasserts, uart_en SHALL rise on the first cycle; during srst, uart_en SHALL be 0.

Verification
REQ-026 Boot scenario: srst released, UART model returns ready 2 cycles after each en.
- Required: write 0x4<-0x4, then write 0x0<-0x01, then init_done=1, then busy=0.
REQ-027 m0 read scenario: m0 reads 0xC, UART returns rdata=0x41.
- Required: m0_rdata=0x41 and m0_ready pulses 1 cycle, one cycle after uart_ready; m1 outputs unchanged.
REQ-028 Contention scenario: m0 and m1 both hold writes continuously, m0 to 0x8 data 0xAA and m1 to 0x8 data 0x55.
- Required: UART sees 0xAA, 0x55, 0xAA, 0x55 (strict alternation).
REQ-029 Early-request scenario: m1 asserts a request during INIT_DIV.
- Required: request is served only after init_done=1; exactly one m1_ready.
REQ-030 Mid-transfer reset scenario: srst for 1 cycle while in XFER.
- Required: no mX_ready pulse; uart_en=0 during srst; 0x4 init write is reissued.
REQ-031 Stalled-UART scenario: UART withholds uart_ready for 100 cycles on m1 access 0x8 data 0x55.
- Required: uart_addr=0x8, uart_wdata=0x55 and uart_en=1 all held stable throughout; m0 request is not granted until completion.
